// File: rtl/ula_seq_if.sv
// Operand/result bundle between the register-file read ports, the sequential ULA and write-back.
// Handshake: start is sampled only while busy=0; busy stays high until the done cycle; done pulses for one cycle.
interface ula_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       select;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             zero;
    logic             carry;
    logic             neg;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, b, select,
        input  busy, done, s, zero, carry, neg, state_dbg
    );

    modport slave (
        input  start, a, b, select,
        output busy, done, s, zero, carry, neg, state_dbg
    );
endinterface

// File: rtl/ula_seq.sv
// Registered Redux-V ULA: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// s and flags are written only on the edge that enters DONE; state_dbg mirrors the FSM state.
module ula_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     rst,
    ula_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       OP_MUL   = 4'd8;
    localparam logic [WIDTH-1:0] W_B      = WIDTH[WIDTH-1:0];
    localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc, mcand, acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [SHW-1:0]       cnt;
    logic [WIDTH-1:0]     alu_s, res_d, rot_amt;
    logic [WIDTH:0]       wide;
    logic                 alu_c, carry_d, load, write_res;
    logic [WIDTH-1:0]     s_q;
    logic                 zero_q, carry_q, neg_q;

    // Single-cycle ops work straight off the bus: they are latched and written on the same edge.
    always_comb begin
        alu_s   = '0;
        alu_c   = 1'b0;
        wide    = '0;
        rot_amt = '0;
        case (bus.select)
            4'd0: alu_s = ~bus.a;
            4'd1: alu_s = bus.a & bus.b;
            4'd2: alu_s = bus.a | bus.b;
            4'd3: alu_s = bus.a ^ bus.b;
            4'd4: begin
                wide  = {1'b0, bus.a} + {1'b0, bus.b};
                alu_s = wide[WIDTH-1:0];
                alu_c = wide[WIDTH];
            end
            4'd5: begin
                wide  = {1'b0, bus.a} - {1'b0, bus.b};
                alu_s = wide[WIDTH-1:0];
                alu_c = wide[WIDTH];
            end
            4'd6: alu_s = (bus.b >= W_B) ? '0 : (bus.a << bus.b);
            4'd7: alu_s = (bus.b >= W_B) ? '0 : (bus.a >> bus.b);
            4'd9: begin
                rot_amt = bus.b % W_B;
                alu_s   = (bus.a << rot_amt) | (bus.a >> (W_B - rot_amt));
            end
            default: alu_s = '0;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        write_res = 1'b0;
        res_d     = alu_s;
        carry_d   = alu_c;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                    if (bus.select == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d   = DONE;
                        write_res = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    state_d   = DONE;
                    write_res = 1'b1;
                    res_d     = acc_next[WIDTH-1:0];
                    carry_d   = |acc_next[2*WIDTH-1:WIDTH];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            s_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            if (load) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                cnt    <= '0;
            end else if (state_q == MUL) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (write_res) begin
                s_q     <= res_d;
                zero_q  <= (res_d == '0);
                carry_q <= carry_d;
                neg_q   <= res_d[WIDTH-1];
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.s         = s_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.neg       = neg_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_ula_seq.sv
// Directed and random checks of ula_seq at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_ula_seq;
    logic clk;
    logic rst;
    int   total_checks;
    int   passed_checks;

    ula_seq_if #(.WIDTH(8))  u8 ();
    ula_seq_if #(.WIDTH(16)) u16 ();

    ula_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(u8));
    ula_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(u16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: returns {carry, s} computed with plain integer arithmetic.
    function automatic logic [32:0] model(input int w, input longint unsigned a,
                                          input longint unsigned b, input logic [3:0] sel);
        longint unsigned mask, r, p;
        logic c;
        mask = (64'd1 << w) - 1;
        r = 0;
        c = 1'b0;
        case (sel)
            4'd0: r = ~a & mask;
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: begin p = a + b; r = p & mask; c = (p > mask); end
            4'd5: begin r = (a - b) & mask; c = (a < b); end
            4'd6: r = (b >= w) ? 0 : ((a << b) & mask);
            4'd7: r = (b >= w) ? 0 : (a >> b);
            4'd8: begin p = a * b; r = p & mask; c = (p > mask); end
            4'd9: begin
                r = a;
                for (int k = 0; k < int'(b % w); k++) r = ((r << 1) | (r >> (w - 1))) & mask;
            end
            default: r = 0;
        endcase
        return {c, r[31:0]};
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
        if (w == 8) begin
            u8.start = st; u8.a = a[7:0]; u8.b = b[7:0]; u8.select = sel;
        end else begin
            u16.start = st; u16.a = a[15:0]; u16.b = b[15:0]; u16.select = sel;
        end
    endtask

    task automatic sample(input int w, output logic d, output logic bz, output logic [31:0] s,
                          output logic z, output logic c, output logic n);
        if (w == 8) begin
            d = u8.done; bz = u8.busy; s = {24'd0, u8.s}; z = u8.zero; c = u8.carry; n = u8.neg;
        end else begin
            d = u16.done; bz = u16.busy; s = {16'd0, u16.s}; z = u16.zero; c = u16.carry; n = u16.neg;
        end
    endtask

    // Issue one op from a negedge, wait (bounded) for done, check latency, result, flags and pulse width.
    task automatic do_op(input string tag, input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] exp_s, input logic exp_c);
        logic d, bz, z, c, n;
        logic [31:0] s;
        int lat;
        bit got;
        drive(w, 1'b1, a, b, sel);
        @(posedge clk);
        #1 drive(w, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
        lat = 0;
        got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            sample(w, d, bz, s, z, c, n);
            if (d) got = 1;
        end
        check({tag, "_lat"}, lat, (sel == 4'd8) ? w + 1 : 1);
        check({tag, "_s"}, s, exp_s);
        check({tag, "_zero"}, {31'd0, z}, {31'd0, exp_s == 0});
        check({tag, "_carry"}, {31'd0, c}, {31'd0, exp_c});
        check({tag, "_neg"}, {31'd0, n}, {31'd0, exp_s[w-1]});
        check({tag, "_busy"}, {31'd0, bz}, 32'd1);
        @(negedge clk);
        sample(w, d, bz, s, z, c, n);
        check({tag, "_pulse"}, {30'd0, d, bz}, 32'd0);
    endtask

    logic [7:0] t1_s [10] = '{8'hB8, 8'h02, 8'h47, 8'h45, 8'h49, 8'h45, 8'h1C, 8'h11, 8'h8E, 8'h1D};

    initial begin
        logic d, bz, z, c, n;
        logic [31:0] s;
        logic [32:0] m;
        logic [31:0] ra, rb;
        logic [3:0]  rsel;
        int w, dones, done_at;

        total_checks = 0;
        passed_checks = 0;
        rst = 1'b1;
        drive(8, 1'b0, 0, 0, 0);
        drive(16, 1'b0, 0, 0, 0);
        repeat (2) @(negedge clk);
        sample(8, d, bz, s, z, c, n);
        check("reset8", {26'd0, d, bz, z, c, n, 1'b0} | s, 32'd0);
        sample(16, d, bz, s, z, c, n);
        check("reset16", {26'd0, d, bz, z, c, n, 1'b0} | s, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("op%0d", i), 8, 32'h47, 32'h02, 4'(i), {24'd0, t1_s[i]}, 1'b0);

        do_op("sub_eq", 8, 32'h47, 32'h47, 4'd5, 32'h00, 1'b0);
        do_op("sub_borrow", 8, 32'h01, 32'h02, 4'd5, 32'hFF, 1'b1);
        do_op("add_wrap", 8, 32'hFF, 32'h01, 4'd4, 32'h00, 1'b1);
        do_op("rol_wrap", 8, 32'h47, 32'h0C, 4'd9, 32'h74, 1'b0);
        do_op("slr_big", 8, 32'h47, 32'h09, 4'd6, 32'h00, 1'b0);
        do_op("mul_zero", 8, 32'h00, 32'h5A, 4'd8, 32'h00, 1'b0);

        // MUL with a start pulse for ADD landing while busy.
        drive(8, 1'b1, 32'h47, 32'h10, 4'd8);
        @(posedge clk);
        #1 drive(8, 1'b0, 32'h01, 32'h02, 4'd4);
        dones = 0;
        done_at = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            sample(8, d, bz, s, z, c, n);
            if (d) begin dones++; done_at = i; end
            drive(8, i == 3, 32'h01, 32'h02, 4'd4);
        end
        check("mul_busy_dones", dones, 1);
        check("mul_busy_lat", done_at, 9);
        sample(8, d, bz, s, z, c, n);
        check("mul_busy_s", s, 32'h70);
        check("mul_busy_carry", {31'd0, c}, 32'd1);

        // Reset in the middle of a MUL.
        drive(8, 1'b1, 32'h47, 32'h47, 4'd8);
        @(posedge clk);
        #1 drive(8, 1'b0, 0, 0, 0);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1 sample(8, d, bz, s, z, c, n);
        check("async_rst_flags", {27'd0, d, bz, z, c, n}, 32'd0);
        check("async_rst_s", s, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            sample(8, d, bz, s, z, c, n);
            if (d || bz) dones++;
        end
        check("rst_no_done", dones, 0);
        do_op("add_after_rst", 8, 32'h03, 32'h04, 4'd4, 32'h07, 1'b0);
        do_op("sel12", 8, 32'hA5, 32'h3C, 4'd12, 32'h00, 1'b0);

        do_op("add16", 16, 32'h1234, 32'h0002, 4'd4, 32'h1236, 1'b0);
        do_op("mul16", 16, 32'h1234, 32'h0002, 4'd8, 32'h2468, 1'b0);

        for (int i = 0; i < 30; i++) begin
            w = (i % 3 == 2) ? 16 : 8;
            ra = $urandom & ((32'd1 << w) - 1);
            rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 2 * w))
                                             : ($urandom & ((32'd1 << w) - 1));
            rsel = 4'($urandom_range(0, 15));
            m = model(w, longint'(ra), longint'(rb), rsel);
            do_op($sformatf("rnd%0d_w%0d_sel%0d", i, w, rsel), w, ra, rb, rsel, m[31:0], m[32]);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
